inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch stage feeding the 8-bit processor core: 8-entry program store, program counter,
//  step-rate tick generator and valid/ready handshake. Replaces the core-internal clock-scaling counter;
//  the core consumes one instruction per handshake. Program is loaded by a host/debug write port.
// PARAMETERS
//  ADDR_W    3           PC / program-store address width; DEPTH = 2**ADDR_W entries
//  DATA_W    8           instruction width
//  TICK_DIV  10000000    clk cycles per fetch step (>=2); bench uses 4
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  load_en      in   1       program-store write strobe
//  load_addr    in   ADDR_W  write address
//  load_data    in   DATA_W  write data
//  run          in   1       1 = fetch continuously at tick rate; 0 = stop after current handshake
//  jump_en      in   1       1-cycle request: next PC = jump_addr
//  jump_addr    in   ADDR_W  jump target
//  inst_valid   out  1       instruction/pc hold a fetched instruction
//  inst_ready   in   1       core accepts instruction this cycle
//  instruction  out  DATA_W  fetched instruction
//  pc           out  ADDR_W  address of presented instruction / next fetch address
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=0, instruction=0, inst_valid=0, tick_cnt=0, jump_pend=0.
//   Program store is NOT reset (contents undefined until loaded). Reset mid-fetch drops the instruction.
//  Store: load_en writes mem[load_addr] in any state. Synchronous read; a same-cycle write to the address
//   being read returns OLD data (read-before-write).
//  tick: tick_cnt counts 0..TICK_DIV-1 only in WAIT_TICK, wraps to 0; tick=1 when tick_cnt==TICK_DIV-1.
//   tick_cnt cleared on entry to WAIT_TICK.
//  FSM:
//   IDLE      : run=1 -> WAIT_TICK.
//   WAIT_TICK : run=0 -> IDLE; tick -> FETCH (read mem[pc] issued).
//   FETCH     : 1 cycle; instruction<=read data, inst_valid<=1 -> PRESENT.
//   PRESENT   : hold instruction/pc/inst_valid stable until inst_valid&inst_ready. On handshake:
//               inst_valid<=0; pc<=jump target if jump pending/asserted, else pc+1 mod DEPTH (7->0);
//               next = run ? WAIT_TICK : IDLE. run dropping in PRESENT never drops the instruction.
//  Latency: WAIT_TICK entry to inst_valid=1 is TICK_DIV+1 cycles. Max rate one instr per TICK_DIV+2 clk.
//  Jump: in IDLE/WAIT_TICK, jump_en loads pc<=jump_addr next cycle (WAIT_TICK continues, tick_cnt kept).
//   In FETCH/PRESENT without handshake, jump_addr latched into jump_pend; applied at handshake.
//   jump_en coincident with handshake: jump_addr wins over pc+1 and over jump_pend. Later jump_en
//   overwrites earlier pending target. jump_pend cleared at handshake.
//  pc is 2**ADDR_W wrap-around unsigned; no overflow flag.
// CONFIGURATION
//  FETCH_SINGLE_STEP_EN defined: extra port `step  in  1` (single-cycle pulse). In IDLE, step=1 with
//   run=0 goes directly to FETCH (no tick wait); after handshake returns to IDLE. step ignored in other
//   states and when run=1.
//  Not defined: no step port; fetch only via run/tick. All other behaviour identical.
// TESTING (TICK_DIV=4)
//  Reset: rst_n=0 mid-PRESENT -> inst_valid=0, pc=0, instruction=8'h00 immediately (async).
//  Load mem[0..7]=8'hC0..8'hC7, run=1, inst_ready=1 -> instructions C0,C1..C7,C0 in order; pc wraps 7->0;
//   first inst_valid 5 cycles after WAIT_TICK entry; subsequent handshakes every 6 cycles.
//  Backpressure: inst_ready=0 for 20 cycles while presenting C2 -> instruction=C2, pc=2, inst_valid=1 stable;
//   after ready, next is C3.
//  Jump: jump_en, jump_addr=5 during PRESENT of pc=1 (no handshake), then handshake -> next is C5; jump_en
//   coincident with handshake, jump_addr=6 -> next is C6.
//  run drop: run=0 while PRESENT -> instruction still delivered, then IDLE, inst_valid stays 0.
//  FETCH_SINGLE_STEP_EN: run=0, three step pulses -> exactly three instructions C0,C1,C2; none without step.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: program store, PC, step-rate tick and valid/ready handshake.
// Optional single-step port enabled by defining FETCH_SINGLE_STEP_EN.
module inst_fetch #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int TICK_DIV = 10000000
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              run,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_TICK, FETCH, PRESENT} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] instr_q;
    logic              valid_q;
    logic [CNT_W-1:0]  tick_cnt_q;
    logic              jump_pend_q;
    logic [ADDR_W-1:0] jump_tgt_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    logic              tick;
    logic              step_go;
    logic              fetch_go;
    logic              handshake;
    logic [ADDR_W-1:0] fetch_addr;

`ifdef FETCH_SINGLE_STEP_EN
    assign step_go = step & ~run;
`else
    assign step_go = 1'b0;
`endif

    assign tick       = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    assign handshake  = (state_q == PRESENT) & valid_q & inst_ready;
    // A jump arriving on the fetch cycle redirects the read so pc and instruction stay paired.
    assign fetch_addr = jump_en ? jump_addr : pc_q;
    assign fetch_go   = ((state_q == WAIT_TICK) & run & tick) |
                        ((state_q == IDLE) & step_go);

    // Program store: unreset, read-before-write on address collision
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
        if (fetch_go) begin
            rdata_q <= mem[fetch_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            tick_cnt_q  <= '0;
            jump_pend_q <= 1'b0;
            jump_tgt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (jump_en) begin
                        pc_q <= jump_addr;
                    end
                    if (step_go) begin
                        state_q <= FETCH;
                    end else if (run) begin
                        state_q    <= WAIT_TICK;
                        tick_cnt_q <= '0;
                    end
                end
                WAIT_TICK: begin
                    if (jump_en) begin
                        pc_q <= jump_addr;
                    end
                    if (!run) begin
                        state_q <= IDLE;
                    end else if (tick) begin
                        state_q    <= FETCH;
                        tick_cnt_q <= '0;
                    end else begin
                        tick_cnt_q <= tick_cnt_q + CNT_W'(1);
                    end
                end
                FETCH: begin
                    instr_q <= rdata_q;
                    valid_q <= 1'b1;
                    state_q <= PRESENT;
                    if (jump_en) begin
                        jump_pend_q <= 1'b1;
                        jump_tgt_q  <= jump_addr;
                    end
                end
                PRESENT: begin
                    if (handshake) begin
                        valid_q     <= 1'b0;
                        jump_pend_q <= 1'b0;
                        if (jump_en) begin
                            pc_q <= jump_addr;
                        end else if (jump_pend_q) begin
                            pc_q <= jump_tgt_q;
                        end else begin
                            pc_q <= pc_q + ADDR_W'(1);
                        end
                        if (run) begin
                            state_q    <= WAIT_TICK;
                            tick_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (jump_en) begin
                        jump_pend_q <= 1'b1;
                        jump_tgt_q  <= jump_addr;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inst_valid  = valid_q;
    assign instruction = instr_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch with TICK_DIV=4: directed steps plus a randomized handshake/jump phase.
module tb_inst_fetch;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int TDIV   = 4;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              step;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              run;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] pc;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mm [DEPTH];
    int                exp_pc;
    bit                pend;
    int                ptgt;

    inst_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_DIV(TDIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef FETCH_SINGLE_STEP_EN
        .step        (step),
`endif
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .run         (run),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .instruction (instruction),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tck();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [DATA_W-1:0] d);
        load_en   = 1'b1;
        load_addr = ADDR_W'(a);
        load_data = d;
        tck();
        load_en = 1'b0;
        mm[a]   = d;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!inst_valid && n < 60) begin
            tck();
            n++;
        end
        if (!inst_valid) chk("valid_timeout", inst_valid, 1);
    endtask

    // Presented instruction must be the model's store content at the model's pc.
    task automatic chk_present(input string tag);
        chk({tag, "_valid"}, inst_valid, 1);
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_instr"}, instruction, mm[exp_pc]);
    endtask

    // Model of a completed handshake: coincident jump, else pending jump, else sequential.
    task automatic model_handshake(input bit jnow, input int jaddr);
        if (jnow) exp_pc = jaddr;
        else if (pend) exp_pc = ptgt;
        else exp_pc = (exp_pc + 1) % DEPTH;
        pend = 0;
    endtask

    task automatic accept(input bit jnow, input int jaddr);
        inst_ready = 1'b1;
        jump_en    = jnow;
        jump_addr  = ADDR_W'(jaddr);
        tck();
        inst_ready = 1'b0;
        jump_en    = 1'b0;
        model_handshake(jnow, jaddr);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; step = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        run = 1'b0; jump_en = 1'b0; jump_addr = '0; inst_ready = 1'b0;
        exp_pc = 0; pend = 0; ptgt = 0;
        #2;
        tck(); tck();
        chk("rst_valid", inst_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instruction, 0);
        rst_n = 1'b1;
        tck();

        for (int i = 0; i < DEPTH; i++) load(i, 8'hC0 + 8'(i));
        tck();
        chk("idle_novalid", inst_valid, 0);

        // Free run: C0..C7,C0 with wrap, one instruction every TDIV+2 cycles.
        run = 1'b1; inst_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            wait_valid(n);
            chk("seq_interval", (k == 0) ? n : n + 1, TDIV + 2);
            chk_present("seq");
            tck();
            chk("seq_drop", inst_valid, 0);
            model_handshake(0, 0);
        end
        inst_ready = 1'b0;

        // Pending jump, coincident jumps, then backpressure on C2.
        wait_valid(n);
        chk_present("pre_jump");
        jump_en = 1'b1; jump_addr = 3'd5;
        tck();
        jump_en = 1'b0;
        pend = 1; ptgt = 5;
        chk_present("jump_hold");
        accept(0, 0);
        wait_valid(n);
        chk_present("jump_pend");
        accept(1, 6);
        wait_valid(n);
        chk_present("jump_coinc");
        accept(1, 2);
        wait_valid(n);
        for (int i = 0; i < 20; i++) begin
            tck();
            chk_present("bp");
        end
        accept(0, 0);
        wait_valid(n);
        chk_present("bp_next");

        // Stop, load a random program while idle, then random ready/jump traffic.
        run = 1'b0;
        accept(0, 0);
        tck(); tck();
        chk("stop_idle", inst_valid, 0);
        for (int i = 0; i < DEPTH; i++) load(i, 8'($urandom));
        run = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (inst_valid) begin
                bit r, j;
                int ja;
                chk_present("rnd");
                r  = 1'($urandom);
                j  = ($urandom_range(0, 3) == 0);
                ja = $urandom_range(0, DEPTH - 1);
                inst_ready = r; jump_en = j; jump_addr = ADDR_W'(ja);
                tck();
                if (r) model_handshake(j, ja);
                else if (j) begin pend = 1; ptgt = ja; end
            end else begin
                inst_ready = 1'($urandom); jump_en = 1'b0;
                tck();
            end
        end
        inst_ready = 1'b0; jump_en = 1'b0;

        // run dropped while presenting: instruction still delivered, then idle.
        wait_valid(n);
        chk_present("rdrop_pre");
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tck();
            chk_present("rdrop_hold");
        end
        accept(0, 0);
        for (int i = 0; i < 15; i++) begin
            chk("rdrop_idle", inst_valid, 0);
            tck();
        end
        chk("rdrop_pc", pc, exp_pc);
        jump_en = 1'b1; jump_addr = 3'd3;
        tck();
        jump_en = 1'b0;
        exp_pc = 3;
        chk("idle_jump_pc", pc, 3);

`ifdef FETCH_SINGLE_STEP_EN
        for (int i = 0; i < DEPTH; i++) load(i, 8'hC0 + 8'(i));
        jump_en = 1'b1; jump_addr = '0;
        tck();
        jump_en = 1'b0;
        exp_pc = 0;
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            tck();
            step = 1'b0;
            wait_valid(n);
            chk("step_lat", n, 1);
            chk_present("step");
            accept(0, 0);
            for (int i = 0; i < 10; i++) begin
                chk("step_none", inst_valid, 0);
                tck();
            end
        end
`endif

        // Asynchronous reset while presenting.
        run = 1'b1; inst_ready = 1'b0;
        wait_valid(n);
        chk_present("arst_pre");
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", inst_valid, 0);
        chk("arst_pc", pc, 0);
        chk("arst_instr", instruction, 0);
        tck();
        rst_n = 1'b1;
        exp_pc = 0; pend = 0;
        wait_valid(n);
        chk_present("arst_resume");
        run = 1'b0;
        accept(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
